bcd_to_bin: RTL
===============

Name: bcd_to_bin

Overview:
- Sequential decimal-to-binary converter. It is the inverse of the display-side binary-to-BCD converter.
- Takes five BCD digits plus a sign code, e.g. from switch/keypad digit entry.
- Produces a 16-bit two's-complement word for the Booth multiplier operand path.
- Uses reverse double-dabble: shift right, then subtract 3 from any BCD digit >= 8. Runs one iteration per clock and reports the result with a one-cycle rdy pulse.

Parameters:
- MINUS_CODE, 4'hA: value on plus_minus that marks a negative number. Any other value means positive.
- ITER, 16: number of shift iterations; equals the output width. Fixed at 16 for this design.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled only in IDLE.
- bcd_d_in_1  in  4  units digit.
- bcd_d_in_2  in  4  tens digit.
- bcd_d_in_3  in  4  hundreds digit.
- bcd_d_in_4  in  4  thousands digit.
- bcd_d_in_5  in  4  ten-thousands digit.
- plus_minus  in  4  sign code; equal to MINUS_CODE means negative.
- bin_d_out  out  16  signed result; held until the next completion.
- err  out  1  last conversion was invalid (bad digit or out of range); held with bin_d_out.
- busy  out  1  conversion in progress.
- rdy  out  1  one-cycle completion strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - bin_d_out=0, err=0, busy=0, rdy=0.
  - Internal 20-bit BCD register, 16-bit shift register, sign flag and 5-bit iteration counter all cleared.
  - Reset mid-conversion aborts it; no rdy is produced. After release, the block waits for a new en.
- IDLE, en=1 sampled at edge k:
  - Capture the digits into bcd_r = {d5,d4,d3,d2,d1}, the sign into neg, clear the shift register and counter.
  - If any digit > 9: go to FINISH with invalid flag set, skipping SHIFT.
  - Otherwise go to SHIFT.
  - busy=1 from edge k.
- SHIFT, one iteration per edge:
  - {bcd_r, sh_r} <= {bcd_r, sh_r} >> 1.
  - Then, on the shifted value, each 4-bit BCD digit >= 8 becomes digit - 3.
  - Both operations complete in the same cycle.
  - Counter increments; after the 16th iteration (edge k+16) go to FINISH.
- FINISH, edge k+17 for valid digits or k+1 for an invalid digit:
  - Range check: overflow if bcd_r != 0 (magnitude >= 65536). Also overflow if neg=0 and magnitude > 32767, or neg=1 and magnitude > 32768.
  - On invalid digit or overflow: err<=1, bin_d_out<=16'h0000.
  - Otherwise: err<=0, and bin_d_out <= neg ? -magnitude : magnitude (16-bit two's complement).
  - Magnitude 0 with neg=1 yields 16'h0000, err=0.
  - Also at this edge: rdy<=1, busy<=0, state<=IDLE.
- rdy is high for exactly one cycle; it is cleared at the following edge.
- The earliest new en is accepted at the edge where rdy is cleared; that edge both clears rdy and starts capture.
- en while busy=1 is ignored; it is not queued.
- Input digits and sign may change after capture without affecting the conversion in progress.
- Latency for valid digits: en edge k -> rdy high after edge k+17, i.e. 17 cycles.
- Total valid range is -32768..+32767 decimal.

Test Plan:
- Digits 1,2,3,4,5 (value 12345), plus_minus=0, en pulse -> busy=1 for 17 cycles; rdy one cycle after edge k+17; bin_d_out=16'h3039, err=0.
- Value 32768 with plus_minus=4'hA -> bin_d_out=16'h8000, err=0. Same digits with plus_minus=0 -> err=1, bin_d_out=16'h0000.
- Value 99999 positive -> err=1, bin_d_out=0, rdy after 17 cycles. Value 00000 with minus -> bin_d_out=0, err=0.
- Digit 3 = 4'hB -> rdy after edge k+1, err=1, bin_d_out=0, busy high for exactly one cycle.
- Value 00007 with minus, then en held high continuously -> bin_d_out=16'hFFF9. en is ignored during busy; the next conversion starts at the edge where rdy falls; two rdy pulses 18 cycles apart.
- Start conversion of 12345, assert reset at cycle 8, release, wait 30 cycles with en=0 -> no rdy; bin_d_out=0, err=0, busy=0. A fresh en afterwards -> 16'h3039.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// Digit-entry / result bundle for the decimal-to-binary converter.
// Master drives digits and start; slave returns the result and status.
interface bcd_to_bin_if;
  logic        en;
  logic [3:0]  bcd_d_in_1;
  logic [3:0]  bcd_d_in_2;
  logic [3:0]  bcd_d_in_3;
  logic [3:0]  bcd_d_in_4;
  logic [3:0]  bcd_d_in_5;
  logic [3:0]  plus_minus;
  logic [15:0] bin_d_out;
  logic        err;
  logic        busy;
  logic        rdy;

  modport master (
    output en, bcd_d_in_1, bcd_d_in_2, bcd_d_in_3,
    output bcd_d_in_4, bcd_d_in_5, plus_minus,
    input  bin_d_out, err, busy, rdy
  );

  modport slave (
    input  en, bcd_d_in_1, bcd_d_in_2, bcd_d_in_3,
    input  bcd_d_in_4, bcd_d_in_5, plus_minus,
    output bin_d_out, err, busy, rdy
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential five-digit signed BCD to 16-bit two's-complement converter.
// Reverse double-dabble: shift right, then subtract 3 from digits >= 8.
module bcd_to_bin #(
  parameter logic [3:0] MINUS_CODE = 4'hA,
  parameter int         ITER       = 16
) (
  input  logic         clk,
  input  logic         reset,
  bcd_to_bin_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] bcd_q, bcd_d;
  logic [15:0] sh_q, sh_d;
  logic        neg_q, neg_d;
  logic        inv_q, inv_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] bin_q, bin_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        rdy_q, rdy_d;

  logic [35:0] wide;
  logic [19:0] bcd_adj;
  logic        bad_dig;
  logic        ovf;

  function automatic logic [3:0] adj3(input logic [3:0] d);
    return (d >= 4'd8) ? d - 4'd3 : d;
  endfunction

  // Datapath helpers: one shift-and-correct step and the range check.
  always_comb begin
    wide    = {bcd_q, sh_q} >> 1;
    bcd_adj = {adj3(wide[35:32]), adj3(wide[31:28]),
               adj3(wide[27:24]), adj3(wide[23:20]),
               adj3(wide[19:16])};
    bad_dig = (bus.bcd_d_in_1 > 4'd9) | (bus.bcd_d_in_2 > 4'd9)
            | (bus.bcd_d_in_3 > 4'd9) | (bus.bcd_d_in_4 > 4'd9)
            | (bus.bcd_d_in_5 > 4'd9);
    ovf     = (bcd_q != 20'd0)
            | (neg_q ? (sh_q > 16'h8000) : (sh_q > 16'h7FFF));
  end

  // Next-state and output decode for the converter FSM.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    sh_d    = sh_q;
    neg_d   = neg_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          bcd_d   = {bus.bcd_d_in_5, bus.bcd_d_in_4,
                     bus.bcd_d_in_3, bus.bcd_d_in_2,
                     bus.bcd_d_in_1};
          neg_d   = (bus.plus_minus == MINUS_CODE);
          inv_d   = bad_dig;
          sh_d    = 16'd0;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          state_d = bad_dig ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        sh_d  = wide[15:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (inv_q || ovf) begin
          err_d = 1'b1;
          bin_d = 16'h0000;
        end else begin
          err_d = 1'b0;
          bin_d = neg_q ? (~sh_q + 16'd1) : sh_q;
        end
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      sh_q    <= '0;
      neg_q   <= 1'b0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      sh_q    <= sh_d;
      neg_q   <= neg_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.bin_d_out = bin_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.rdy       = rdy_q;

endmodule
